de_pipe_reg: RTL and testbench
==============================

Name: de_pipe_reg

Overview:
- Decode-to-Execute pipeline register for the 64-bit Y86-64 pipelined core.
- Captures decode-stage results each clock and presents them to the execute stage, where the 64-bit 2:1 operand-select muxes consume E_valA/E_valB/E_valC.
- Implements the hazard-control protocol: normal load, stall (hold) and bubble (inject NOP).
- Keeps saturating performance counters for stalls and bubbles.

Parameters:
- W, 64, data-path width of valA/valB/valC.
- CW, 32, width of stall/bubble performance counters.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- E_stall  input  1  hold current contents.
- E_bubble  input  1  load NOP bubble.
- d_stat  input  3  decode status code.
- d_icode  input  4  instruction code.
- d_ifun  input  4  function code.
- d_valA  input  W  operand A.
- d_valB  input  W  operand B.
- d_valC  input  W  constant word.
- d_dstE  input  4  ALU destination register ID.
- d_dstM  input  4  memory destination register ID.
- d_srcA  input  4  source register A ID.
- d_srcB  input  4  source register B ID.
- E_stat, E_icode, E_ifun, E_valA, E_valB, E_valC, E_dstE, E_dstM, E_srcA, E_srcB  output  (widths as inputs)  registered copies.
- E_valid  output  1  1 = real instruction, 0 = bubble/reset.
- stall_cnt  output  CW  cycles with E_stall=1.
- bubble_cnt  output  CW  cycles with a bubble loaded.

Behaviour:
- One clock domain. All outputs are registered. Latency is 1 cycle from d_* to E_*.
- Reset (rst_n=0, asynchronous, takes effect immediately, independent of clk) loads the bubble state:
  - E_stat=3'd1 (SAOK), E_icode=4'h1 (INOP), E_ifun=0.
  - E_valA=E_valB=E_valC=0.
  - E_dstE=E_dstM=E_srcA=E_srcB=4'hF (RNONE).
  - E_valid=0, stall_cnt=0, bubble_cnt=0.
- Reset deassertion is synchronous to the design. The first capturing edge is the first rising clk with rst_n=1.
- Per rising edge, priority order:
  1. E_stall=1: all E_* and E_valid hold; stall_cnt increments.
  2. Else if E_bubble=1: load the reset bubble values; E_valid=0; bubble_cnt increments.
  3. Else: load all d_* fields; E_valid=1.
- Stall and bubble asserted together: the stall wins and the register holds. stall_cnt increments and bubble_cnt does not. The hazard unit should never do this, but the behaviour is defined.
- Counters saturate at 2^CW-1 and do not wrap.
- Counters are cleared only by reset.
- Fields are passed through unmodified. There is no width conversion or sign extension.
- No combinational path from any input to any output.
- Reset mid-operation (any cycle, including during a stall) forces the bubble state immediately. The pending stall/bubble is discarded.

Test Plan:
1. Reset with clk running; release; d_icode=4'h6, d_ifun=0, d_valA=64'h5, d_valB=64'h7, d_dstE=4'h3, stall=bubble=0 -> next edge: E_icode=6, E_valA=5, E_valB=7, E_dstE=3, E_valid=1. Before the edge: NOP/RNONE values with E_valid=0.
2. After loading valA=64'hDEAD_BEEF_0000_0001, hold E_stall=1 for 3 edges while d_* changes every cycle -> E_* unchanged for 3 cycles; stall_cnt=3; bubble_cnt=0.
3. E_bubble=1 for 1 edge with d_icode=4'h5 -> E_icode=1, E_ifun=0, E_val*=0, E_dst*/src*=4'hF, E_stat=1, E_valid=0, bubble_cnt=1. Next edge with bubble=0 loads icode 5.
4. E_stall=1 and E_bubble=1 together for 2 edges -> E_* held; stall_cnt+=2; bubble_cnt unchanged.
5. Assert rst_n=0 mid-cycle, between edges, during a stall -> outputs take the bubble values immediately, without a clk edge; counters=0.
6. Run with CW=4 and E_stall=1 for 20 edges -> stall_cnt reaches 15 and stays at 15.

Source files
------------

// File: rtl/de_pipe_reg_if.sv
// Decode-to-execute bundle: decode-stage fields in, registered execute-stage copies out.
interface de_pipe_reg_if #(
   parameter int W = 64
);
   logic [2:0]   d_stat;
   logic [3:0]   d_icode;
   logic [3:0]   d_ifun;
   logic [W-1:0] d_valA;
   logic [W-1:0] d_valB;
   logic [W-1:0] d_valC;
   logic [3:0]   d_dstE;
   logic [3:0]   d_dstM;
   logic [3:0]   d_srcA;
   logic [3:0]   d_srcB;

   logic [2:0]   E_stat;
   logic [3:0]   E_icode;
   logic [3:0]   E_ifun;
   logic [W-1:0] E_valA;
   logic [W-1:0] E_valB;
   logic [W-1:0] E_valC;
   logic [3:0]   E_dstE;
   logic [3:0]   E_dstM;
   logic [3:0]   E_srcA;
   logic [3:0]   E_srcB;
   logic         E_valid;

   modport master (
      output d_stat, d_icode, d_ifun, d_valA, d_valB, d_valC,
             d_dstE, d_dstM, d_srcA, d_srcB,
      input  E_stat, E_icode, E_ifun, E_valA, E_valB, E_valC,
             E_dstE, E_dstM, E_srcA, E_srcB, E_valid
   );

   modport slave (
      input  d_stat, d_icode, d_ifun, d_valA, d_valB, d_valC,
             d_dstE, d_dstM, d_srcA, d_srcB,
      output E_stat, E_icode, E_ifun, E_valA, E_valB, E_valC,
             E_dstE, E_dstM, E_srcA, E_srcB, E_valid
   );
endinterface

// File: rtl/de_pipe_reg.sv
// Y86-64 decode-to-execute pipeline register with stall/bubble hazard control
// and saturating stall/bubble performance counters.
module de_pipe_reg #(
   parameter int W  = 64,
   parameter int CW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          E_stall,
   input  logic          E_bubble,
   de_pipe_reg_if.slave  bus,
   output logic [CW-1:0] stall_cnt,
   output logic [CW-1:0] bubble_cnt
);

   typedef struct packed {
      logic [2:0]   stat;
      logic [3:0]   icode;
      logic [3:0]   ifun;
      logic [W-1:0] valA;
      logic [W-1:0] valB;
      logic [W-1:0] valC;
      logic [3:0]   dstE;
      logic [3:0]   dstM;
      logic [3:0]   srcA;
      logic [3:0]   srcB;
   } stage_t;

   // SAOK / INOP / zero operands / RNONE registers: the state after reset and every bubble
   localparam stage_t BUBBLE = {3'd1, 4'h1, 4'h0, {(3*W){1'b0}}, 16'hFFFF};

   stage_t        stage_d, stage_q;
   logic          valid_d, valid_q;
   logic [CW-1:0] stallCnt_d, stallCnt_q;
   logic [CW-1:0] bubbleCnt_d, bubbleCnt_q;

   always_comb begin
      stage_d     = stage_q;
      valid_d     = valid_q;
      stallCnt_d  = stallCnt_q;
      bubbleCnt_d = bubbleCnt_q;
      // Stall outranks bubble so a simultaneous request holds rather than flushes
      if (E_stall) begin
         if (stallCnt_q != {CW{1'b1}})
            stallCnt_d = stallCnt_q + CW'(1);
      end else if (E_bubble) begin
         stage_d = BUBBLE;
         valid_d = 1'b0;
         if (bubbleCnt_q != {CW{1'b1}})
            bubbleCnt_d = bubbleCnt_q + CW'(1);
      end else begin
         stage_d = {bus.d_stat, bus.d_icode, bus.d_ifun,
                    bus.d_valA, bus.d_valB, bus.d_valC,
                    bus.d_dstE, bus.d_dstM, bus.d_srcA, bus.d_srcB};
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage_q     <= BUBBLE;
         valid_q     <= 1'b0;
         stallCnt_q  <= '0;
         bubbleCnt_q <= '0;
      end else begin
         stage_q     <= stage_d;
         valid_q     <= valid_d;
         stallCnt_q  <= stallCnt_d;
         bubbleCnt_q <= bubbleCnt_d;
      end
   end

   assign bus.E_stat  = stage_q.stat;
   assign bus.E_icode = stage_q.icode;
   assign bus.E_ifun  = stage_q.ifun;
   assign bus.E_valA  = stage_q.valA;
   assign bus.E_valB  = stage_q.valB;
   assign bus.E_valC  = stage_q.valC;
   assign bus.E_dstE  = stage_q.dstE;
   assign bus.E_dstM  = stage_q.dstM;
   assign bus.E_srcA  = stage_q.srcA;
   assign bus.E_srcB  = stage_q.srcB;
   assign bus.E_valid = valid_q;
   assign stall_cnt   = stallCnt_q;
   assign bubble_cnt  = bubbleCnt_q;

endmodule

// File: tb/tb_de_pipe_reg.sv
// Self-checking bench for de_pipe_reg: vector table with a scoreboard queue,
// plus hand-written async-reset and counter-saturation sequences.
module tb_de_pipe_reg;

   logic        clk;
   logic        rst_n;
   logic        stall, bubble;
   logic        stall4;
   logic [31:0] stallCnt, bubbleCnt;
   logic [3:0]  stallCnt4, bubbleCnt4;
   int          total = 0;
   int          bad   = 0;

   de_pipe_reg_if #(.W(64)) bus ();
   de_pipe_reg_if #(.W(64)) bus4 ();

   de_pipe_reg #(.W(64), .CW(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .E_stall    (stall),
      .E_bubble   (bubble),
      .bus        (bus.slave),
      .stall_cnt  (stallCnt),
      .bubble_cnt (bubbleCnt)
   );

   de_pipe_reg #(.W(64), .CW(4)) dut4 (
      .clk        (clk),
      .rst_n      (rst_n),
      .E_stall    (stall4),
      .E_bubble   (1'b0),
      .bus        (bus4.slave),
      .stall_cnt  (stallCnt4),
      .bubble_cnt (bubbleCnt4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout want finish");
      $fatal(1, "[TB] watchdog expired");
   end

   typedef struct {
      logic        stall, bubble;
      logic [2:0]  stat;
      logic [3:0]  icode, ifun;
      logic [63:0] valA, valB, valC;
      logic [15:0] regs;
      logic [2:0]  eStat;
      logic [3:0]  eIcode, eIfun;
      logic [63:0] eValA, eValB, eValC;
      logic [15:0] eRegs;
      logic        eValid;
      logic [31:0] eScnt, eBcnt;
   } vec_t;

   vec_t tbl[12];
   vec_t sbQ[$];

   function automatic vec_t mkVec(
      logic s, logic b, logic [2:0] st, logic [3:0] ic, logic [3:0] fn,
      logic [63:0] a, logic [63:0] bb, logic [63:0] c, logic [15:0] r,
      logic [2:0] eSt, logic [3:0] eIc, logic [3:0] eFn,
      logic [63:0] eA, logic [63:0] eB, logic [63:0] eC, logic [15:0] eR,
      logic eV, logic [31:0] eS, logic [31:0] eBc);
      vec_t v;
      v.stall = s;     v.bubble = b;   v.stat = st;   v.icode = ic;  v.ifun = fn;
      v.valA = a;      v.valB = bb;    v.valC = c;    v.regs = r;
      v.eStat = eSt;   v.eIcode = eIc; v.eIfun = eFn;
      v.eValA = eA;    v.eValB = eB;   v.eValC = eC;  v.eRegs = eR;
      v.eValid = eV;   v.eScnt = eS;   v.eBcnt = eBc;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Drives one vector onto the decode side and queues the value expected after the edge
   task automatic applyStimulus(input vec_t v);
      stall        = v.stall;
      bubble       = v.bubble;
      bus.d_stat   = v.stat;
      bus.d_icode  = v.icode;
      bus.d_ifun   = v.ifun;
      bus.d_valA   = v.valA;
      bus.d_valB   = v.valB;
      bus.d_valC   = v.valC;
      {bus.d_dstE, bus.d_dstM, bus.d_srcA, bus.d_srcB} = v.regs;
      sbQ.push_back(v);
   endtask

   task automatic checkOutput(input int idx);
      vec_t e;
      total++;
      if (sbQ.size() == 0) begin
         bad++;
         $display("[TB] FAIL scoreboard[%0d]: got empty queue want entry", idx);
         return;
      end
      total--;
      e = sbQ.pop_front();
      chk($sformatf("v%0d.stat", idx),  64'(bus.E_stat),  64'(e.eStat));
      chk($sformatf("v%0d.icode", idx), 64'(bus.E_icode), 64'(e.eIcode));
      chk($sformatf("v%0d.ifun", idx),  64'(bus.E_ifun),  64'(e.eIfun));
      chk($sformatf("v%0d.valA", idx),  bus.E_valA, e.eValA);
      chk($sformatf("v%0d.valB", idx),  bus.E_valB, e.eValB);
      chk($sformatf("v%0d.valC", idx),  bus.E_valC, e.eValC);
      chk($sformatf("v%0d.regs", idx),
          64'({bus.E_dstE, bus.E_dstM, bus.E_srcA, bus.E_srcB}), 64'(e.eRegs));
      chk($sformatf("v%0d.valid", idx), 64'(bus.E_valid), 64'(e.eValid));
      chk($sformatf("v%0d.stallCnt", idx),  64'(stallCnt),  64'(e.eScnt));
      chk($sformatf("v%0d.bubbleCnt", idx), 64'(bubbleCnt), 64'(e.eBcnt));
   endtask

   task automatic checkBubble(input string tag);
      chk({tag, ".stat"},  64'(bus.E_stat),  64'd1);
      chk({tag, ".icode"}, 64'(bus.E_icode), 64'h1);
      chk({tag, ".ifun"},  64'(bus.E_ifun),  64'h0);
      chk({tag, ".valA"},  bus.E_valA, 64'h0);
      chk({tag, ".valB"},  bus.E_valB, 64'h0);
      chk({tag, ".valC"},  bus.E_valC, 64'h0);
      chk({tag, ".regs"},  64'({bus.E_dstE, bus.E_dstM, bus.E_srcA, bus.E_srcB}), 64'hFFFF);
      chk({tag, ".valid"}, 64'(bus.E_valid), 64'h0);
      chk({tag, ".stallCnt"},  64'(stallCnt),  64'h0);
      chk({tag, ".bubbleCnt"}, 64'(bubbleCnt), 64'h0);
   endtask

   localparam logic [63:0] A1 = 64'hDEAD_BEEF_0000_0001;

   initial begin
      int expSat;

      tbl[0]  = mkVec(0,0, 1,4'h6,4'h0, 64'h5, 64'h7, 64'h0, 16'h3F24,
                      1,4'h6,4'h0, 64'h5, 64'h7, 64'h0, 16'h3F24, 1, 0, 0);
      tbl[1]  = mkVec(0,0, 1,4'h3,4'h0, A1, 64'h0, 64'h100, 16'h2FFF,
                      1,4'h3,4'h0, A1, 64'h0, 64'h100, 16'h2FFF, 1, 0, 0);
      tbl[2]  = mkVec(1,0, 1,4'h7,4'h1, 64'h1111, 64'h2222, 64'h3333, 16'h1234,
                      1,4'h3,4'h0, A1, 64'h0, 64'h100, 16'h2FFF, 1, 1, 0);
      tbl[3]  = mkVec(1,0, 2,4'h8,4'h2, 64'h4444, 64'h5555, 64'h6666, 16'h5678,
                      1,4'h3,4'h0, A1, 64'h0, 64'h100, 16'h2FFF, 1, 2, 0);
      tbl[4]  = mkVec(1,0, 3,4'h9,4'h3, 64'h7777, 64'h8888, 64'h9999, 16'h9ABC,
                      1,4'h3,4'h0, A1, 64'h0, 64'h100, 16'h2FFF, 1, 3, 0);
      tbl[5]  = mkVec(0,1, 1,4'h5,4'h0, 64'h55, 64'h66, 64'h77, 16'h0123,
                      1,4'h1,4'h0, 64'h0, 64'h0, 64'h0, 16'hFFFF, 0, 3, 1);
      tbl[6]  = mkVec(0,0, 1,4'h5,4'h0, 64'h11, 64'h22, 64'h33, 16'h5F67,
                      1,4'h5,4'h0, 64'h11, 64'h22, 64'h33, 16'h5F67, 1, 3, 1);
      tbl[7]  = mkVec(1,1, 1,4'hA,4'h2, 64'h99, 64'h98, 64'h97, 16'h0000,
                      1,4'h5,4'h0, 64'h11, 64'h22, 64'h33, 16'h5F67, 1, 4, 1);
      tbl[8]  = mkVec(1,1, 4,4'hB,4'h3, 64'hA1, 64'hA2, 64'hA3, 16'hEEEE,
                      1,4'h5,4'h0, 64'h11, 64'h22, 64'h33, 16'h5F67, 1, 5, 1);
      tbl[9]  = mkVec(0,0, 2,4'h0,4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'h1, 16'hABCD,
                      2,4'h0,4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'h1, 16'hABCD, 1, 5, 1);
      tbl[10] = mkVec(0,1, 1,4'h6,4'h1, 64'h12, 64'h34, 64'h56, 16'h1111,
                      1,4'h1,4'h0, 64'h0, 64'h0, 64'h0, 16'hFFFF, 0, 5, 2);
      tbl[11] = mkVec(0,1, 1,4'h7,4'h2, 64'h78, 64'h9A, 64'hBC, 16'h2222,
                      1,4'h1,4'h0, 64'h0, 64'h0, 64'h0, 16'hFFFF, 0, 5, 3);

      rst_n  = 1'b0;
      stall  = 1'b0;
      bubble = 1'b0;
      stall4 = 1'b0;
      bus.d_stat = '0; bus.d_icode = '0; bus.d_ifun = '0;
      bus.d_valA = '0; bus.d_valB = '0;  bus.d_valC = '0;
      bus.d_dstE = '0; bus.d_dstM = '0;  bus.d_srcA = '0; bus.d_srcB = '0;
      bus4.d_stat = '0; bus4.d_icode = '0; bus4.d_ifun = '0;
      bus4.d_valA = '0; bus4.d_valB = '0;  bus4.d_valC = '0;
      bus4.d_dstE = '0; bus4.d_dstM = '0;  bus4.d_srcA = '0; bus4.d_srcB = '0;

      repeat (3) @(posedge clk);
      #1;
      checkBubble("reset");
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkBubble("preEdge");

      for (int i = 0; i < 12; i++) begin
         if (i > 0) @(negedge clk);
         applyStimulus(tbl[i]);
         @(posedge clk);
         #1;
         checkOutput(i);
      end

      // Async reset mid-cycle during a stall, after loading a real instruction
      @(negedge clk);
      stall = 1'b0; bubble = 1'b0;
      bus.d_icode = 4'h2; bus.d_valA = 64'hABC;
      {bus.d_dstE, bus.d_dstM, bus.d_srcA, bus.d_srcB} = 16'h1234;
      @(posedge clk);
      #1;
      chk("preRst.valid", 64'(bus.E_valid), 64'h1);
      chk("preRst.valA",  bus.E_valA, 64'hABC);
      @(negedge clk);
      stall = 1'b1;
      @(posedge clk);
      #1;
      chk("preRst.stallCnt", 64'(stallCnt), 64'd6);
      #2;
      rst_n = 1'b0;
      #1;
      checkBubble("asyncRst");

      // Narrow-counter instance: stall held for 20 edges saturates at 15
      @(negedge clk);
      stall  = 1'b0;
      rst_n  = 1'b1;
      stall4 = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         expSat = (i + 1 > 15) ? 15 : i + 1;
         chk($sformatf("sat4[%0d]", i), 64'(stallCnt4), 64'(expSat));
      end
      chk("sat4.bubbleCnt", 64'(bubbleCnt4), 64'h0);
      chk("sat4.valid",     64'(bus4.E_valid), 64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
